// File: rtl/jpeg_byte_packer.sv
// Packs right-aligned Huffman codewords MSB-first into bytes, stuffs 0x00 after
// every 0xFF data byte, and on end-of-image pads with 1s and appends FF D9.
module jpeg_byte_packer #(
  parameter int CODE_W = 32,
  parameter int ACC_W  = 64,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic [5:0]        in_len,
  input  logic              in_eoi,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic              err
);

  typedef enum logic [2:0] {S_RUN, S_STUFF, S_PAD, S_MK_FF, S_MK_D9} state_t;

  localparam logic [CNT_W-1:0] THR    = CNT_W'(ACC_W - CODE_W);
  localparam logic [CNT_W-1:0] C8     = CNT_W'(8);
  localparam logic [6:0]       MAXLEN = 7'(CODE_W);

  state_t             st_q, st_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               eoi_q, eoi_d, err_q, err_d;
  logic               ov_q, ov_d, ol_q, ol_d;
  logic [7:0]         ob_q, ob_d;

  logic               ld_ok, accept, len_ok;
  logic               emit, emit_last;
  logic [7:0]         emit_byte, top8, pad8;
  logic [ACC_W-1:0]   top_sh, pad_sh, code_ext;

  // Live bits sit right-aligned in acc_q[cnt_q-1:0]; the oldest bit is the highest.
  assign in_ready = !rst && (st_q == S_RUN) && !eoi_q && (cnt_q <= THR);
  assign accept   = in_valid && in_ready;
  assign len_ok   = ({1'b0, in_len} <= MAXLEN);
  assign ld_ok    = !ov_q || out_ready;

  assign top_sh   = acc_q >> (cnt_q - C8);
  assign top8     = top_sh[7:0];
  assign pad_sh   = acc_q << (C8 - cnt_q);
  assign pad8     = pad_sh[7:0] | (8'hFF >> cnt_q);
  assign code_ext = ACC_W'(in_code) & ~({ACC_W{1'b1}} << in_len);

  always_ff @(posedge clk) begin
    if (rst) st_q <= S_RUN;
    else     st_q <= st_d;
  end

  // Every transition waits for the output register to be free, so a stalled
  // sink freezes the marker/stuff sequence in place.
  always_comb begin
    st_d = st_q;
    if (ld_ok) begin
      unique case (st_q)
        S_RUN: begin
          if (cnt_q >= C8) begin
            if (top8 == 8'hFF)                     st_d = S_STUFF;
            else if (eoi_q && (cnt_q - C8) < C8)   st_d = (cnt_q != C8) ? S_PAD : S_MK_FF;
          end else if (eoi_q) begin
            st_d = (cnt_q != '0) ? S_PAD : S_MK_FF;
          end
        end
        S_STUFF: st_d = S_RUN;
        S_PAD:   st_d = (pad8 == 8'hFF) ? S_STUFF : S_MK_FF;
        S_MK_FF: st_d = S_MK_D9;
        S_MK_D9: st_d = S_RUN;
        default: st_d = S_RUN;
      endcase
    end
  end

  always_comb begin
    emit      = 1'b0;
    emit_byte = 8'h00;
    emit_last = 1'b0;
    unique case (st_q)
      S_RUN: begin
        emit      = ld_ok && (cnt_q >= C8);
        emit_byte = top8;
      end
      S_STUFF: emit = ld_ok;
      S_PAD: begin
        emit      = ld_ok;
        emit_byte = pad8;
      end
      S_MK_FF: begin
        emit      = ld_ok;
        emit_byte = 8'hFF;
      end
      S_MK_D9: begin
        emit      = ld_ok;
        emit_byte = 8'hD9;
        emit_last = 1'b1;
      end
      default: emit = 1'b0;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    eoi_d = eoi_q;
    err_d = err_q;
    if (emit && st_q == S_RUN) cnt_d = cnt_q - C8;
    if (emit && st_q == S_PAD) cnt_d = '0;
    // New bits enter below the existing ones, so a same-cycle emit is unaffected.
    if (accept) begin
      if (len_ok) begin
        acc_d = (acc_q << in_len) | code_ext;
        cnt_d = cnt_d + CNT_W'(in_len);
      end else begin
        err_d = 1'b1;
      end
      if (in_eoi) eoi_d = 1'b1;
    end
    if (emit && st_q == S_MK_D9) begin
      eoi_d = 1'b0;
      acc_d = '0;
    end
  end

  always_comb begin
    ov_d = ov_q;
    ob_d = ob_q;
    ol_d = ol_q;
    if (ld_ok) begin
      ov_d = emit;
      if (emit) begin
        ob_d = emit_byte;
        ol_d = emit_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      eoi_q <= 1'b0;
      err_q <= 1'b0;
      ov_q  <= 1'b0;
      ob_q  <= 8'h00;
      ol_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      eoi_q <= eoi_d;
      err_q <= err_d;
      ov_q  <= ov_d;
      ob_q  <= ob_d;
      ol_q  <= ol_d;
    end
  end

  assign out_valid = ov_q;
  assign out_byte  = ob_q;
  assign out_last  = ol_q;
  assign err       = err_q;

endmodule

// File: tb/tb_jpeg_byte_packer.sv
// Bench for jpeg_byte_packer: a bit-queue model predicts the byte stream, a
// negedge monitor compares every transferred byte, plus literal sequence checks.
module tb_jpeg_byte_packer;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_eoi = 1'b0, out_ready = 1'b0;
  logic [31:0] in_code = '0;
  logic [5:0]  in_len = '0;
  logic        in_ready, out_valid, out_last, err;
  logic [7:0]  out_byte;

  jpeg_byte_packer #(.CODE_W(32), .ACC_W(64), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .in_len(in_len), .in_eoi(in_eoi),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_last(out_last), .err(err)
  );

  always #5 clk = ~clk;

  int         checks = 0, failures = 0;
  bit         bitq[$];
  logic [8:0] expq[$], got[$];
  logic [8:0] e;
  bit         err_m = 1'b0;
  int         acc_cnt = 0;
  int         or_mode = 1;
  logic       rst_q = 1'b0;
  logic       hold_v = 1'b0, hold_l = 1'b0;
  logic [7:0] hold_b = '0;
  bit         t4_done = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void push_data(input logic [7:0] b);
    expq.push_back({1'b0, b});
    if (b == 8'hFF) expq.push_back(9'h000);
  endfunction

  // Byte stream follows directly from the accepted bit string.
  function automatic void model_accept(input logic [31:0] code, input logic [5:0] len, input logic eoi);
    logic [7:0] b;
    b = 8'hFF;
    if (len > 6'd32) err_m = 1'b1;
    else for (int i = int'(len) - 1; i >= 0; i--) bitq.push_back(code[i]);
    while (bitq.size() >= 8) begin
      for (int i = 0; i < 8; i++) b = {b[6:0], bitq.pop_front()};
      push_data(b);
    end
    if (eoi) begin
      if (bitq.size() > 0) begin
        b = 8'hFF;
        for (int i = 0; bitq.size() > 0; i++) b[7-i] = bitq.pop_front();
        push_data(b);
      end
      expq.push_back(9'h0FF);
      expq.push_back(9'h1D9);
    end
  endfunction

  always @(posedge clk) rst_q <= rst;

  always @(negedge clk) begin
    if (rst_q) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_byte", out_byte, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_err", err, 0);
    end
    if (rst) begin
      chk("rst_in_ready", in_ready, 0);
      bitq.delete();
      expq.delete();
      err_m  = 1'b0;
      hold_v = 1'b0;
    end else begin
      chk("err", err, err_m);
      if (hold_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_byte", out_byte, hold_b);
        chk("hold_last", out_last, hold_l);
      end
      hold_v = out_valid && !out_ready;
      hold_b = out_byte;
      hold_l = out_last;
      if (out_valid && out_ready) begin
        got.push_back({out_last, out_byte});
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_extra: got byte %h last %b, expected none", out_byte, out_last);
        end else begin
          e = expq.pop_front();
          chk("out_byte_last", {out_last, out_byte}, e);
        end
      end
      if (in_valid && in_ready) begin
        acc_cnt++;
        model_accept(in_code, in_len, in_eoi);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (or_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [31:0] c, input logic [5:0] l, input logic eo);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    in_valid = 1'b1; in_code = c; in_len = l; in_eoi = eo;
    while (!ok && n < 3000) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    in_eoi   = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got no in_ready, expected acceptance within 3000 cycles");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    or_mode = 1;
    while ((expq.size() != 0 || out_valid) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 5000) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d bytes still pending, expected 0", expq.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_seq(input string nm, input logic [8:0] ref_q[$]);
    chk({nm, "_count"}, got.size(), ref_q.size());
    for (int i = 0; i < ref_q.size(); i++)
      chk($sformatf("%s[%0d]", nm, i), (i < got.size()) ? got[i] : 9'bx, ref_q[i]);
  endtask

  initial begin
    int n, bad;
    logic [5:0] l;
    logic       eo;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // FF then 11+eoi: stuffing on data and on the padded byte
    got.delete();
    send(32'hFF, 6'd8, 1'b0);
    send(32'h3, 6'd2, 1'b1);
    drain();
    check_seq("t1", '{9'h0FF, 9'h000, 9'h0FF, 9'h000, 9'h0FF, 9'h1D9});

    got.delete();
    send(32'h5, 6'd3, 1'b0);
    send(32'h1A, 6'd5, 1'b0);
    drain();
    check_seq("t2", '{9'h0BA});

    got.delete();
    send(32'h0, 6'd1, 1'b1);
    drain();
    check_seq("t3", '{9'h07F, 9'h0FF, 9'h1D9});

    // Sink stalled: only two 32-bit words fit before in_ready drops
    got.delete();
    acc_cnt = 0;
    t4_done = 1'b0;
    or_mode = 2;
    fork
      begin
        for (int k = 0; k < 40; k++) send(32'hAAAAAAAA, 6'd32, 1'b0);
        t4_done = 1'b1;
      end
    join_none
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t4_stall_accepts", acc_cnt, 2);
    chk("t4_stall_in_ready", in_ready, 0);
    @(posedge clk); #1;
    or_mode = 0;
    n = 0;
    while (!t4_done && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t4_sender_done", t4_done, 1);
    drain();
    chk("t4_count", got.size(), 160);
    bad = 0;
    foreach (got[i]) if (got[i] !== 9'h0AA) bad++;
    chk("t4_non_aa", bad, 0);

    got.delete();
    send(32'h0, 6'd40, 1'b1);
    drain();
    chk("t6_err", err, 1);
    check_seq("t6", '{9'h0FF, 9'h1D9});

    // Reset mid-image drops the 5 leftover bits
    send(32'h1ABC, 6'd13, 1'b0);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    got.delete();
    @(negedge clk);
    chk("t5_err_cleared", err, 0);
    @(posedge clk); #1;
    send(32'h0, 6'd0, 1'b1);
    drain();
    check_seq("t5", '{9'h0FF, 9'h1D9});

    or_mode = 0;
    for (int k = 0; k < 300; k++) begin
      l  = ($urandom_range(0, 29) == 0) ? 6'($urandom_range(33, 63)) : 6'($urandom_range(0, 32));
      eo = ($urandom_range(0, 9) == 0);
      send($urandom, l, eo);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    send(32'h0, 6'd0, 1'b1);
    drain();
    chk("rand_model_empty", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jpeg_byte_packer.md
Name: jpeg_byte_packer

Overview:
- Downstream of the JPEG coder.
- Consumes variable-length Huffman codewords and packs them MSB-first into a byte stream.
- Applies JPEG byte stuffing: a 0x00 is inserted after every 0xFF data byte.
- On end-of-image: pads the final partial byte with 1s, then appends the EOI marker FF D9.
- Output feeds the frame writer / DMA byte FIFO through a valid/ready handshake.

Parameters:
- CODE_W, 32: maximum codeword length in bits. in_code is right-aligned.
- ACC_W, 64: bit accumulator depth. Must be ≥ CODE_W + 8.
- CNT_W, 7: width of the accumulator bit count. Must hold the value ACC_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  codeword present
- in_ready  out  1  packer accepts the codeword this cycle
- in_code  in  CODE_W  codeword, right-aligned; bits above in_len are ignored
- in_len  in  6  codeword length, 0..CODE_W
- in_eoi  in  1  last codeword of the image
- out_valid  out  1  byte present
- out_ready  in  1  sink accepts the byte
- out_byte  out  8  packed byte
- out_last  out  1  asserted with the final D9 byte
- err  out  1  sticky: a codeword with in_len > CODE_W was dropped

Behaviour:
- Reset (checked at clk edge while rst=1) forces:
  - state=RUN, acc=0, count=0, eoi_pend=0
  - out_valid=0, out_byte=0x00, out_last=0, err=0
  - in_ready=0 during reset cycles
  - Reset mid-image discards all buffered bits and any pending byte; no flush and no marker.
- Input acceptance:
  - Accept when in_valid && in_ready.
  - in_ready = (state==RUN) && !eoi_pend && (count ≤ ACC_W−CODE_W). Uses the registered count only.
  - On accept: the low in_len bits of in_code are appended below the existing bits; count += in_len.
  - in_len=0 is legal: no bits are added, in_eoi is still honoured.
  - in_len>CODE_W: codeword is dropped, err is set, in_eoi is still honoured.
  - in_eoi accepted sets eoi_pend.
- Output register:
  - Loads when (!out_valid || out_ready) and a byte is available.
  - out_byte and out_last hold stable while out_valid && !out_ready.
  - Accept and emit may occur in the same cycle. Net count = count + in_len − 8.
  - Latency: a codeword accepted at edge N that completes a byte gives out_valid at edge N+1 at the earliest.
- States:
  - RUN:
    - count ≥ 8: emit the top 8 bits and subtract 8 from count.
    - If the emitted byte is 0xFF, go to STUFF.
    - Else if eoi_pend && count<8 (after the emit): go to PAD if count>0, else to MK_FF.
  - STUFF: emit 0x00, then return to RUN. The stuff byte is never itself stuffed.
  - PAD:
    - Emit the remaining count bits followed by (8−count) 1s, then set count=0.
    - If the padded byte is 0xFF, go to STUFF (eoi_pend still set). Otherwise go to MK_FF.
  - MK_FF: emit 0xFF without stuffing, go to MK_D9.
  - MK_D9: emit 0xD9 with out_last=1. Clear eoi_pend and acc, then go to RUN.
- Boundary conditions:
  - Accumulator full (count > ACC_W−CODE_W): in_ready=0 until emits drain it. No bit is lost.
  - Output stalled: the state machine does not advance. Input continues until the accumulator is full.
  - Zero-bit image (EOI with count=0): output is exactly FF D9.

Test Plan:
1. code=0xFF len=8, then code=0x3 len=2 with eoi → bytes FF 00 FF(11+111111, padded) 00 FF D9. out_last only on D9.
2. code=0b101 len=3, then 0b11010 len=5 → single byte 0xBA. No stuffing.
3. code=0 len=1 eoi=1 → 0x7F, FF, D9 (last).
4. Forty codewords of 0xAAAAAAAA len=32 with out_ready low for 20 cycles then random:
   - in_ready drops once count > 32.
   - Output is 160 bytes of 0xAA, in order, with no loss or duplication.
5. After 13 bits are buffered, rst=1 for 1 cycle, then code=0 len=0 eoi=1:
   - All outputs are zero during reset.
   - Output afterwards is only FF D9.
6. in_len=40 with eoi=1 on an empty accumulator → err=1 (sticky until rst). Output FF D9. No data byte emitted.
